// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register with load-use detection and registered forward selects.
// Optional: define HAZ_STALL_CNT_EN to add the saturating stall_cnt output.
module id_exe_pipe_reg #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [DATA_W-1:0]   id_rs_val,
  input  logic [DATA_W-1:0]   id_rt_val,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  input  logic [REG_AW-1:0]   id_dest,
  input  logic                id_uses_rt,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_alu_src,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [REG_AW-1:0]   mem_dest,
  input  logic                mem_reg_write,
  input  logic                flush,
  output logic                ex_valid,
  output logic [DATA_W-1:0]   ex_rs_val,
  output logic [DATA_W-1:0]   ex_rt_val,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [REG_AW-1:0]   ex_rt,
  output logic [REG_AW-1:0]   ex_dest,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_alu_src,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [1:0]          forward_op1,
  output logic [1:0]          forward_op2,
  output logic                stall
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  typedef struct packed {
    logic                valid;
    logic [DATA_W-1:0]   rs_val;
    logic [DATA_W-1:0]   rt_val;
    logic [DATA_W-1:0]   imm;
    logic [REG_AW-1:0]   rt;
    logic [REG_AW-1:0]   dest;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          fwd1;
    logic [1:0]          fwd2;
  } ex_t;

  ex_t  q;
  ex_t  d;
  logic load_use;
  logic bubble;
  logic ex_wr;

  // EXE/MEM producer (one stage ahead) beats MEM/WB producer.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              exe_wr,
    input logic [REG_AW-1:0] exe_d,
    input logic              mwr,
    input logic [REG_AW-1:0] md
  );
    logic [1:0] sel;
    sel = 2'd0;
    priority case (1'b1)
      (src == '0):           sel = 2'd0;
      (exe_wr && exe_d == src): sel = 2'd2;
      (mwr && md == src):    sel = 2'd1;
      default:               sel = 2'd0;
    endcase
    return sel;
  endfunction

  assign ex_wr = q.valid & q.reg_write;

  always_comb begin
    load_use = q.valid & q.mem_read
             & (q.dest != '0) & id_valid
             & ((q.dest == id_rs)
               | (id_uses_rt & (q.dest == id_rt)));
  end

  assign stall  = load_use & ~flush;
  assign bubble = flush | load_use | ~id_valid;

  always_comb begin
    d = '0;
    if (!bubble) begin
      d.valid     = 1'b1;
      d.rs_val    = id_rs_val;
      d.rt_val    = id_rt_val;
      d.imm       = id_imm;
      d.rt        = id_rt;
      d.dest      = id_dest;
      d.reg_write = id_reg_write;
      d.mem_read  = id_mem_read;
      d.mem_write = id_mem_write;
      d.alu_src   = id_alu_src;
      d.alu_op    = id_alu_op;
      d.fwd1 = fwd_sel(id_rs, ex_wr, q.dest,
                       mem_reg_write, mem_dest);
      d.fwd2 = fwd_sel(id_rt, ex_wr, q.dest,
                       mem_reg_write, mem_dest);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

  assign ex_valid     = q.valid;
  assign ex_rs_val    = q.rs_val;
  assign ex_rt_val    = q.rt_val;
  assign ex_imm       = q.imm;
  assign ex_rt        = q.rt;
  assign ex_dest      = q.dest;
  assign ex_reg_write = q.reg_write;
  assign ex_mem_read  = q.mem_read;
  assign ex_mem_write = q.mem_write;
  assign ex_alu_src   = q.alu_src;
  assign ex_alu_op    = q.alu_op;
  assign forward_op1  = q.fwd1;
  assign forward_op2  = q.fwd2;

`ifdef HAZ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
